// File: rtl/adc_seq.sv
// ADC acquisition sequencer: request/settle/wait handshake, 16-sample moving average,
// sticky alarm/error flags. Define ADC_SEQ_PEAK_EN to add the peak-hold output.
module adc_seq #(
  parameter int PERIOD  = 64,
  parameter int SETTLE  = 3,
  parameter int TIMEOUT = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cont,
  input  logic       stop,
  input  logic [7:0] thresh,
  output logic       adc_req,
  output logic       adc_rst,
  input  logic       adc_rdy,
  input  logic [7:0] adc_dat,
  output logic       busy,
  output logic [7:0] smp,
  output logic       smp_vld,
  output logic [7:0] avg,
  output logic [4:0] cnt,
  output logic       alarm,
  output logic       err
`ifdef ADC_SEQ_PEAK_EN
  ,
  output logic [7:0] peak
`endif
);

  localparam int PW = $clog2(PERIOD);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] PERIOD_LAST  = PW'(PERIOD - 1);
  localparam logic [TW-1:0] SETTLE_C     = TW'(SETTLE);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_STORE,
    S_GAP
  } state_t;

  state_t          state_q, state_d;
  logic            cont_q, cont_d;
  logic            stop_seen_q, stop_seen_d;
  logic [TW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [PW-1:0]   per_cnt_q, per_cnt_d;
  logic            rdy_s1_q, rdy_s1_d;
  logic            rdy_s2_q, rdy_s2_d;
  logic [7:0]      smp_q, smp_d;
  logic            smp_vld_q, smp_vld_d;
  logic [7:0]      ring_q [16];
  logic [7:0]      ring_d [16];
  logic [3:0]      ptr_q, ptr_d;
  logic [11:0]     sum_q, sum_d;
  logic [4:0]      cnt_q, cnt_d;
  logic            alarm_q, alarm_d;
  logic            err_q, err_d;
  logic            adc_rst_q, adc_rst_d;
  logic            capture;
  logic            timeout;
`ifdef ADC_SEQ_PEAK_EN
  logic [7:0]      peak_q, peak_d;
`endif

  // FSM: next state and handshake decisions
  always_comb begin
    state_d     = state_q;
    cont_d      = cont_q;
    stop_seen_d = stop_seen_q;
    wait_cnt_d  = wait_cnt_q;
    per_cnt_d   = per_cnt_q + PW'(1);
    capture     = 1'b0;
    timeout     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_REQ;
          cont_d      = cont;
          stop_seen_d = 1'b0;
          per_cnt_d   = '0;
        end
      end
      S_REQ: begin
        state_d     = S_WAIT;
        wait_cnt_d  = '0;
        stop_seen_d = stop_seen_q | stop;
      end
      S_WAIT: begin
        wait_cnt_d  = wait_cnt_q + TW'(1);
        stop_seen_d = stop_seen_q | stop;
        if (wait_cnt_q >= SETTLE_C && rdy_s2_q) begin
          state_d = S_STORE;
          capture = 1'b1;
        end else if (wait_cnt_q == TIMEOUT_LAST) begin
          state_d = S_IDLE;
          timeout = 1'b1;
        end
      end
      S_STORE: begin
        if (!cont_q || stop_seen_q || stop) state_d = S_IDLE;
        else                                state_d = S_GAP;
      end
      S_GAP: begin
        // per_cnt was zeroed on REQ entry, so this fixes the REQ-to-REQ spacing
        if (stop) begin
          state_d = S_IDLE;
        end else if (per_cnt_q == PERIOD_LAST) begin
          state_d     = S_REQ;
          stop_seen_d = 1'b0;
          per_cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: captured on the WAIT->STORE edge so STORE shows a consistent result
  always_comb begin
    rdy_s1_d  = adc_rdy;
    rdy_s2_d  = rdy_s1_q;
    smp_d     = smp_q;
    smp_vld_d = capture;
    ring_d    = ring_q;
    ptr_d     = ptr_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    alarm_d   = alarm_q;
    err_d     = err_q | timeout;
    adc_rst_d = timeout;
    if (capture) begin
      smp_d         = adc_dat;
      ring_d[ptr_q] = adc_dat;
      ptr_d         = ptr_q + 4'd1;
      sum_d         = sum_q + 12'(adc_dat) - 12'(ring_q[ptr_q]);
      cnt_d         = (cnt_q == 5'd16) ? cnt_q : cnt_q + 5'd1;
      alarm_d       = alarm_q | (adc_dat > thresh);
    end
  end

`ifdef ADC_SEQ_PEAK_EN
  always_comb begin
    peak_d = peak_q;
    if (capture && adc_dat > peak_q) peak_d = adc_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) peak_q <= '0;
    else     peak_q <= peak_d;
  end

  assign peak = peak_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cont_q      <= 1'b0;
      stop_seen_q <= 1'b0;
      wait_cnt_q  <= '0;
      per_cnt_q   <= '0;
      rdy_s1_q    <= 1'b0;
      rdy_s2_q    <= 1'b0;
      smp_q       <= '0;
      smp_vld_q   <= 1'b0;
      for (int i = 0; i < 16; i++) ring_q[i] <= '0;
      ptr_q       <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      alarm_q     <= 1'b0;
      err_q       <= 1'b0;
      adc_rst_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cont_q      <= cont_d;
      stop_seen_q <= stop_seen_d;
      wait_cnt_q  <= wait_cnt_d;
      per_cnt_q   <= per_cnt_d;
      rdy_s1_q    <= rdy_s1_d;
      rdy_s2_q    <= rdy_s2_d;
      smp_q       <= smp_d;
      smp_vld_q   <= smp_vld_d;
      ring_q      <= ring_d;
      ptr_q       <= ptr_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      alarm_q     <= alarm_d;
      err_q       <= err_d;
      adc_rst_q   <= adc_rst_d;
    end
  end

  assign adc_req = (state_q == S_REQ) || (state_q == S_WAIT);
  assign adc_rst = rst | adc_rst_q;
  assign busy    = (state_q != S_IDLE);
  assign smp     = smp_q;
  assign smp_vld = smp_vld_q;
  assign avg     = sum_q[11:4];
  assign cnt     = cnt_q;
  assign alarm   = alarm_q;
  assign err     = err_q;

endmodule

// File: tb/tb_adc_seq.sv
// Bench for adc_seq: behavioural ADC model, scoreboard of delivered samples and a
// window-history reference for cnt/avg/alarm/peak.
module tb_adc_seq;
  localparam int PERIOD  = 64;
  localparam int SETTLE  = 3;
  localparam int TIMEOUT = 32;

  logic       clk = 1'b0;
  logic       rst, start, cont, stop;
  logic [7:0] thresh;
  logic       adc_req, adc_rst, adc_rdy;
  logic [7:0] adc_dat;
  logic       busy;
  logic [7:0] smp;
  logic       smp_vld;
  logic [7:0] avg;
  logic [4:0] cnt;
  logic       alarm, err;
`ifdef ADC_SEQ_PEAK_EN
  logic [7:0] peak;
`endif

  adc_seq #(.PERIOD(PERIOD), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .stop(stop), .thresh(thresh),
    .adc_req(adc_req), .adc_rst(adc_rst), .adc_rdy(adc_rdy), .adc_dat(adc_dat),
    .busy(busy), .smp(smp), .smp_vld(smp_vld), .avg(avg), .cnt(cnt),
    .alarm(alarm), .err(err)
`ifdef ADC_SEQ_PEAK_EN
    , .peak(peak)
`endif
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard and reference state
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] hist[$];
  logic       exp_alarm = 1'b0;
  logic [7:0] exp_peak = 8'h00;
  int         vld_count = 0;
  int         adc_mode = 0;   // 0 respond, 1 never ready, 2 slow respond
  int         tbl_idx = 0;
  logic [7:0] tbl [17] = '{8'h8B, 8'h91, 8'h91, 8'h91, 8'h91, 8'h91, 8'h91, 8'h91,
                           8'h91, 8'hD7, 8'h91, 8'h91, 8'h91, 8'h91, 8'h98, 8'h8C,
                           8'h90};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic [7:0] ref_avg();
    int s = 0;
    int lo = (hist.size() > 16) ? hist.size() - 16 : 0;
    for (int i = lo; i < hist.size(); i++) s += hist[i];
    return 8'(s / 16);
  endfunction

  function automatic logic [4:0] ref_cnt();
    return (hist.size() > 16) ? 5'd16 : 5'(hist.size());
  endfunction

  // ADC model: drops ready on each request, presents new data after a delay
  initial begin
    logic req_prev = 1'b0;
    logic aborted;
    int   d;
    logic [7:0] v;
    adc_rdy = 1'b0;
    adc_dat = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (adc_req && !req_prev) begin
        adc_rdy = 1'b0;
        if (adc_mode != 1) begin
          d = (adc_mode == 2) ? 25 : $urandom_range(0, 20);
          aborted = 1'b0;
          for (int i = 0; i < d; i++) begin
            @(posedge clk); #1;
            if (!adc_req) aborted = 1'b1;
          end
          if (!aborted && adc_req) begin
            if (tbl_idx < 17) begin v = tbl[tbl_idx]; tbl_idx++; end
            else v = 8'($urandom_range(0, 255));
            adc_dat = v;
            adc_rdy = 1'b1;
            exp_q.push_back(v);
          end
        end
      end
      req_prev = adc_req;
    end
  end

  // monitor: timing of requests and captured results against the reference
  initial begin
    logic req_d = 1'b0;
    int   prev_req = -1;
    int   req_cyc = 0;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst || !busy) prev_req = -1;
      if (!rst) begin
        if (adc_req && !req_d) begin
          if (prev_req >= 0) check("req_period", cyc - prev_req, PERIOD);
          prev_req = cyc;
          req_cyc  = cyc;
        end
        if (smp_vld) begin
          vld_count++;
          check("latency_in_range",
                ((cyc - req_cyc) >= SETTLE + 2) && ((cyc - req_cyc) <= TIMEOUT + 2), 1);
          check("sb_nonempty", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            hist.push_back(e);
            if (e > thresh) exp_alarm = 1'b1;
            if (e > exp_peak) exp_peak = e;
            check("smp", smp, e);
            check("cnt", cnt, ref_cnt());
            check("avg", avg, ref_avg());
            check("alarm", alarm, exp_alarm);
`ifdef ADC_SEQ_PEAK_EN
            check("peak", peak, exp_peak);
`endif
          end
        end
      end
      req_d = adc_req;
    end
  end

  // driver tasks
  task automatic clear_model();
    exp_q.delete();
    hist.delete();
    exp_alarm = 1'b0;
    exp_peak  = 8'h00;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    clear_model();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic do_start(input logic c);
    @(posedge clk); #1;
    start = 1'b1;
    cont  = c;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(posedge clk); #1;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
  endtask

  task automatic wait_vld(input string tag, input int n);
    int b = 0;
    while (vld_count < n && b < 3000) begin
      @(negedge clk); #1;
      b++;
    end
    if (vld_count < n) check(tag, vld_count, n);
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int b = 0;
    while (busy && b < bound) begin
      @(negedge clk); #1;
      b++;
    end
    if (busy) check(tag, busy, 0);
  endtask

  initial begin
    int base;
    int n;
    rst = 1'b1; start = 1'b0; cont = 1'b0; stop = 1'b0; thresh = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_adc_rst", adc_rst, 1);
    check("rst_busy", busy, 0);
    check("rst_adc_req", adc_req, 0);
    check("rst_cnt", cnt, 0);
    check("rst_avg", avg, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    #1;
    check("adc_rst_low", adc_rst, 0);

    // single sample from a fresh model
    tbl_idx = 0;
    base = vld_count;
    do_start(1'b0);
    wait_vld("single_vld", base + 1);
    check("single_smp", smp, 8'h8B);
    check("single_cnt", cnt, 1);
    check("single_avg", avg, 8'h08);
    wait_idle("single_idle", 20);
    repeat (80) @(negedge clk);
    check("single_one_vld", vld_count - base, 1);
    check("single_busy", busy, 0);

    // continuous: 17 directed samples, wrap, then stop in GAP
    do_reset();
    tbl_idx = 0;
    thresh  = 8'hC0;
    base = vld_count;
    do_start(1'b1);
    wait_vld("cont9", base + 9);
    check("alarm_before_10", alarm, 0);
    wait_vld("cont10", base + 10);
    check("alarm_at_10", alarm, 1);
    wait_vld("cont16", base + 16);
    check("cont_cnt16", cnt, 16);
    check("cont_avg16", avg, 8'h95);
`ifdef ADC_SEQ_PEAK_EN
    check("cont_peak", peak, 8'hD7);
`endif
    wait_vld("cont17", base + 17);
    check("wrap_cnt", cnt, 16);
    check("wrap_avg", avg, 8'h95);
    check("alarm_sticky", alarm, 1);
    pulse_stop();
    @(negedge clk);
    check("stop_gap_idle", busy, 0);

    // stop during WAIT finishes the current sample only
    base = vld_count;
    do_start(1'b1);
    wait_vld("stopw_first", base + 1);
    n = 0;
    while (!adc_req && n < 200) begin @(negedge clk); n++; end
    check("stopw_req_seen", adc_req, 1);
    pulse_stop();
    wait_idle("stopw_idle", 100);
    repeat (80) @(negedge clk);
    check("stopw_vld_count", vld_count - base, 2);

    // ready never arrives: timeout
    adc_mode = 1;
    base = vld_count;
    do_start(1'b0);
    @(negedge clk);
    n = 0;
    while (adc_req && n < 200) begin @(negedge clk); n++; end
    check("to_req_cycles", n, TIMEOUT + 1);
    check("to_adc_rst", adc_rst, 1);
    check("to_err", err, 1);
    check("to_busy", busy, 0);
    @(negedge clk);
    check("to_adc_rst_1cyc", adc_rst, 0);
    check("to_err_sticky", err, 1);
    check("to_no_vld", vld_count - base, 0);

    // reset in the middle of WAIT
    adc_mode = 2;
    base = vld_count;
    do_start(1'b1);
    repeat (4) @(negedge clk);
    check("rw_in_wait", adc_req, 1);
    rst = 1'b1;
    clear_model();
    #1;
    check("rw_adc_rst_comb", adc_rst, 1);
    @(posedge clk); #1;
    check("rw_busy", busy, 0);
    check("rw_adc_req", adc_req, 0);
    check("rw_smp", smp, 0);
    check("rw_smp_vld", smp_vld, 0);
    check("rw_avg", avg, 0);
    check("rw_cnt", cnt, 0);
    check("rw_alarm", alarm, 0);
    check("rw_err", err, 0);
    rst = 1'b0;
    #1;
    check("rw_adc_rst_rel", adc_rst, 0);
    repeat (60) @(negedge clk);
    check("rw_no_vld", vld_count - base, 0);
    clear_model();

    // randomized continuous run
    adc_mode = 0;
    tbl_idx  = 17;
    do_reset();
    thresh = 8'($urandom_range(0, 255));
    base = vld_count;
    do_start(1'b1);
    wait_vld("rand_cont", base + 20);
    repeat ($urandom_range(0, 60)) @(posedge clk);
    pulse_stop();
    wait_idle("rand_idle", 200);

    // randomized single samples
    for (int k = 0; k < 5; k++) begin
      thresh = 8'($urandom_range(0, 255));
      base = vld_count;
      do_start(1'b0);
      wait_vld("rand_single", base + 1);
      wait_idle("rand_single_idle", 50);
    end
    repeat (5) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/adc_seq.md
ADC_SEQ -- requirements
Module: adc_seq

Interface
REQ-001 Parameter PERIOD, default 64: clk cycles from one request start to the next in continuous mode (min 8).
REQ-002 Parameter SETTLE, default 3: clk cycles after adc_req rises before adc_rdy is examined.
REQ-003 Parameter TIMEOUT, default 32: clk cycles in WAIT without ready before abort.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 start  in  1  one-cycle pulse; begins acquisition from IDLE.
REQ-007 cont  in  1  sampled at start: 1 = continuous, 0 = single sample.
REQ-008 stop  in  1  ends continuous acquisition after the current sample.
REQ-009 thresh  in  8  alarm threshold, unsigned.
REQ-010 adc_req  out  1  request to ADC; converter acts on its rising edge.
REQ-011 adc_rst  out  1  reset to ADC.
REQ-012 adc_rdy  in  1  ADC ready, asynchronous to clk, level (may stay high between samples).
REQ-013 adc_dat  in  8  ADC data, stable whenever adc_rdy is high.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 smp  out  8  last captured sample; smp_vld  out  1  one-cycle pulse on capture.
REQ-016 avg  out  8  moving average of last 16 samples; cnt  out  5  samples in window (0..16).
REQ-017 alarm  out  1  sticky: a captured sample was strictly greater than thresh.
REQ-018 err  out  1  sticky: a request timed out.

Function
REQ-019 adc_rdy SHALL pass through a 2-flop synchronizer; all uses of ready refer to the synchronized value.
REQ-020 FSM states SHALL be IDLE, REQ, WAIT, STORE, GAP.
REQ-021 IDLE: start=1 -> REQ, latch cont; start ignored in every other state.
REQ-022 REQ: adc_req=1 for exactly one cycle; -> WAIT next cycle; adc_req stays high through WAIT, drops on exit from WAIT.
REQ-023 WAIT: first SETTLE cycles ignore ready; thereafter ready=1 -> STORE; TIMEOUT cycles total in WAIT without ready -> IDLE, err=1, adc_rst=1 for one cycle.
REQ-024 STORE (one cycle): smp<=adc_dat, smp_vld=1, write to 16-entry ring, update sum, alarm|=(adc_dat>thresh).
REQ-025 Running sum 12 bits: sum <= sum + new - entry overwritten; ring entries reset to 0; avg = sum[11:4] (zeros count before 16 samples).
REQ-026 cnt increments per capture, saturates at 16; write pointer wraps 15->0.
REQ-027 STORE -> IDLE if single mode or stop seen since request start; else -> GAP.
REQ-028 GAP: waits so consecutive REQ entries are exactly PERIOD cycles apart; stop in GAP -> IDLE immediately.
REQ-029 stop and timeout in same cycle: timeout behaviour wins.
REQ-030 Sample-to-smp_vld latency: SETTLE+2 minimum after REQ, bounded by TIMEOUT+2.

Reset
REQ-031 rst=1 SHALL force IDLE and adc_req=0, smp=0, smp_vld=0, avg=0, cnt=0, alarm=0, err=0, ring and sum cleared, pointer 0, synchronizer cleared.
REQ-032 adc_rst SHALL be 1 while rst=1 (combinational), and 0 otherwise except timeout pulse.
REQ-033 rst mid-acquisition SHALL abort without a capture; next start begins fresh window.

Configuration
REQ-034 Macro ADC_SEQ_PEAK_EN defined: add output peak (8 bits), max captured sample since reset, updated in STORE, reset 0.
REQ-035 ADC_SEQ_PEAK_EN undefined: no peak port, no peak register; all other behaviour identical.

Verification
REQ-036 Single: start, cont=0, ADC model fresh -> one smp_vld, smp=0x8B, cnt=1, avg=0x08, busy low after.
REQ-037 Continuous 16 samples with model sequence 0x8B..0x8C -> cnt=16, sum 0x952, avg=0x95; REQ starts 64 cycles apart.
REQ-038 thresh=0xC0 continuous -> alarm rises on capture 10 (0xD7), stays high; PEAK_EN build: peak=0xD7.
REQ-039 adc_rdy tied low -> after 32 WAIT cycles err=1, one-cycle adc_rst, FSM IDLE, no smp_vld.
REQ-040 17th sample in continuous mode -> pointer wraps, oldest (0x8B) removed from sum, cnt stays 16.
REQ-041 rst asserted during WAIT -> all outputs to reset values next edge, adc_rst high with rst.
